clk_div_prog: RTL

Runtime-programmable clock divider / clock-enable generator, the parametrised successor of the fixed divide-by-4 divider. It produces a registered divided clock with programmable period and high time, plus single-cycle rise/fall strobes for downstream logic clocked on sys_clk. New divisor and high-time settings load through a valid/ready handshake. They take effect only at a period boundary, so the output never shows a runt pulse.

---
 rtl/clk_div_pkg.sv | 15 +
 rtl/clk_div_prog_if.sv | 11 +
 rtl/div_cfg_slot.sv | 43 ++++
 rtl/clk_div_prog.sv | 58 +++++
 4 files changed

// File: rtl/clk_div_pkg.sv
// Shared constants and types for the programmable clock divider.
// The divider's cfg records are sized by PKG_CNT_W; retarget that value to change the width.
package clk_div_pkg;
  localparam int PKG_CNT_W    = 8;
  localparam int PKG_DEF_DIV  = 4;
  localparam int PKG_DEF_HIGH = 2;
  localparam int MIN_DIV      = 2;

  typedef struct packed {
    logic [PKG_CNT_W-1:0] div;
    logic [PKG_CNT_W-1:0] high;
  } div_cfg_t;

  typedef enum logic {SLOT_EMPTY = 1'b0, SLOT_FULL = 1'b1} slot_state_t;
endpackage

// File: rtl/clk_div_prog_if.sv
// Config request channel: divisor/high-time with valid/ready and a reject pulse.
interface clk_div_prog_if #(parameter int CNT_W = clk_div_pkg::PKG_CNT_W);
  logic             cfg_valid;
  logic             cfg_ready;
  logic             cfg_err;
  logic [CNT_W-1:0] div_in;
  logic [CNT_W-1:0] high_in;

  modport master (output cfg_valid, div_in, high_in, input cfg_ready, cfg_err);
  modport slave  (input cfg_valid, div_in, high_in, output cfg_ready, cfg_err);
endinterface

// File: rtl/div_cfg_slot.sv
// One-entry pending config slot: accepts legal requests, rejects div<2, frees on apply.
module div_cfg_slot import clk_div_pkg::*; #(
  parameter int CNT_W = PKG_CNT_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             valid,
  input  logic [CNT_W-1:0] div_in,
  input  logic [CNT_W-1:0] high_in,
  input  logic             apply,
  output logic             ready,
  output logic             err,
  output logic             pend_vld,
  output div_cfg_t         pend
);
  slot_state_t state, state_nxt;
  logic        legal;

  assign legal    = (div_in >= CNT_W'(MIN_DIV));
  assign ready    = (state == SLOT_EMPTY);
  assign pend_vld = (state == SLOT_FULL);

  always_comb begin
    state_nxt = state;
    case (state)
      SLOT_EMPTY: if (valid && legal) state_nxt = SLOT_FULL;
      SLOT_FULL:  if (apply)          state_nxt = SLOT_EMPTY;
      default:                        state_nxt = SLOT_EMPTY;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= SLOT_EMPTY;
      err   <= 1'b0;
      pend  <= '0;
    end else begin
      state <= state_nxt;
      err   <= ready & valid & ~legal;
      if (ready && valid && legal) pend <= '{div: div_in, high: high_in};
    end
  end
endmodule

// File: rtl/clk_div_prog.sv
// Programmable divided clock with rise/fall strobes; new settings swap in only
// at a period boundary (or immediately while parked) so no runt pulse appears.
module clk_div_prog import clk_div_pkg::*; #(
  parameter int CNT_W    = PKG_CNT_W,
  parameter int DEF_DIV  = PKG_DEF_DIV,
  parameter int DEF_HIGH = PKG_DEF_HIGH
) (
  input  logic             sys_clk,
  input  logic             sys_rst,
  input  logic             en,
  clk_div_prog_if.slave    cfg,
  output logic             fen_clk,
  output logic             rise_tick,
  output logic             fall_tick,
  output logic [CNT_W-1:0] cur_div
);
  logic [CNT_W-1:0] cnt, cur_high;
  logic             wrap, apply, pend_vld, fen_nxt;
  div_cfg_t         pend;

  assign wrap    = (cnt == cur_div - CNT_W'(1));
  assign apply   = pend_vld & (~en | wrap);
  // output lags the counter by one cycle; parked forces low
  assign fen_nxt = en & (cnt < cur_high);

  div_cfg_slot #(.CNT_W(CNT_W)) u_slot (
    .clk      (sys_clk),
    .rst      (sys_rst),
    .valid    (cfg.cfg_valid),
    .div_in   (cfg.div_in),
    .high_in  (cfg.high_in),
    .apply    (apply),
    .ready    (cfg.cfg_ready),
    .err      (cfg.cfg_err),
    .pend_vld (pend_vld),
    .pend     (pend)
  );

  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      cnt       <= '0;
      fen_clk   <= 1'b0;
      rise_tick <= 1'b0;
      fall_tick <= 1'b0;
      cur_div   <= CNT_W'(DEF_DIV);
      cur_high  <= CNT_W'(DEF_HIGH);
    end else begin
      cnt       <= (!en || wrap) ? '0 : cnt + CNT_W'(1);
      fen_clk   <= fen_nxt;
      rise_tick <= fen_nxt & ~fen_clk;
      fall_tick <= ~fen_nxt & fen_clk;
      if (apply) begin
        cur_div  <= pend.div;
        cur_high <= pend.high;
      end
    end
  end
endmodule
